// File: rtl/add_sub_result_decoder.sv
// Decodes {M, co, s} adder/subtractor results into signed values, keeps a saturating
// running sum and result count, and forwards each decoded item on a valid/ready stream.
module add_sub_result_decoder #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_m,
  input  logic              in_co,
  input  logic [DATA_W-1:0] in_s,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W+1:0] out_value,
  output logic [ACC_W-1:0]  out_acc,
  output logic              acc_sat,
  output logic [CNT_W-1:0]  cnt,
  output logic              err_malformed
);

  localparam int W = DATA_W + 2;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc;
  logic             xfer;
  logic [W-1:0]     dec_value;
  logic             malformed;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum;
  logic             clamp;
  logic [ACC_W-1:0] acc_upd;
  logic             sat_upd;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_upd;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  // Subtract results are sign-magnitude; co=0 with s=0 is a negative zero.
  always_comb begin
    dec_value = '0;
    malformed = 1'b0;
    if (!in_m) begin
      dec_value = {1'b0, in_co, in_s};
    end else if (in_co) begin
      dec_value = {2'b00, in_s};
    end else begin
      dec_value = (~{2'b00, in_s}) + {{(W-1){1'b0}}, 1'b1};
      malformed = (in_s == '0);
    end
  end

  // One extra bit of headroom is enough: |value| is always below 2^(ACC_W-1).
  always_comb begin
    acc_base = acc_clr ? '0 : acc;
    sum      = {acc_base[ACC_W-1], acc_base}
             + {{(ACC_W+1-W){dec_value[W-1]}}, dec_value};
    clamp    = (sum[ACC_W] != sum[ACC_W-1]);
    acc_upd  = acc_base;
    if (xfer) begin
      if (!clamp) begin
        acc_upd = sum[ACC_W-1:0];
      end else if (sum[ACC_W]) begin
        acc_upd = ACC_MIN;
      end else begin
        acc_upd = ACC_MAX;
      end
    end
    sat_upd  = (acc_clr ? 1'b0 : acc_sat) | (xfer & clamp);
    cnt_base = acc_clr ? '0 : cnt;
    cnt_upd  = cnt_base;
    if (xfer && !(&cnt_base)) begin
      cnt_upd = cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_value     <= '0;
      out_acc       <= '0;
      acc_sat       <= 1'b0;
      cnt           <= '0;
      err_malformed <= 1'b0;
      acc           <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_value <= dec_value;
        out_acc   <= acc_upd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      acc           <= acc_upd;
      acc_sat       <= sat_upd;
      cnt           <= cnt_upd;
      err_malformed <= err_malformed | (xfer & malformed);
    end
  end

endmodule

// File: tb/tb_add_sub_result_decoder.sv
// Self-checking bench for add_sub_result_decoder: directed sequences, a decode table
// and randomized traffic, all scored against an integer-arithmetic reference model.
module tb_add_sub_result_decoder;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 16;
  localparam longint ACC_MAX = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W-1));
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_m = 1'b0;
  logic              in_co = 1'b0;
  logic [DATA_W-1:0] in_s = '0;
  logic              acc_clr = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W+1:0] out_value;
  logic [ACC_W-1:0]  out_acc;
  logic              acc_sat;
  logic [CNT_W-1:0]  cnt;
  logic              err_malformed;

  add_sub_result_decoder #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_m(in_m), .in_co(in_co), .in_s(in_s), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_acc(out_acc), .acc_sat(acc_sat), .cnt(cnt), .err_malformed(err_malformed)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state, kept as plain signed integers.
  bit     m_valid = 1'b0;
  bit     m_sat   = 1'b0;
  bit     m_err   = 1'b0;
  longint m_value = 0;
  longint m_out_acc = 0;
  longint m_acc = 0;
  longint m_cnt = 0;

  task automatic cmp(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint decode(input bit m, input bit co, input longint s);
    if (!m) return (co ? (longint'(1) << DATA_W) : 0) + s;
    return co ? s : -s;
  endfunction

  function automatic longint sv_value();
    return longint'($signed(out_value));
  endfunction

  function automatic longint sv_acc();
    return longint'($signed(out_acc));
  endfunction

  task automatic model_edge();
    bit     xfer;
    longint v;
    longint s;
    if (!rst_n) begin
      m_valid = 0; m_sat = 0; m_err = 0;
      m_value = 0; m_out_acc = 0; m_acc = 0; m_cnt = 0;
      return;
    end
    xfer = in_valid && (!m_valid || out_ready);
    if (acc_clr) begin
      m_acc = 0; m_sat = 0; m_cnt = 0;
    end
    if (xfer) begin
      v = decode(in_m, in_co, longint'(in_s));
      s = m_acc + v;
      if (s > ACC_MAX) begin s = ACC_MAX; m_sat = 1; end
      if (s < ACC_MIN) begin s = ACC_MIN; m_sat = 1; end
      m_acc = s;
      m_out_acc = s;
      m_value = v;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (in_m && !in_co && in_s == 0) m_err = 1;
      m_valid = 1;
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ".out_valid"}, longint'(out_valid), longint'(m_valid));
    cmp({tag, ".out_value"}, sv_value(), m_value);
    cmp({tag, ".out_acc"}, sv_acc(), m_out_acc);
    cmp({tag, ".acc_sat"}, longint'(acc_sat), longint'(m_sat));
    cmp({tag, ".cnt"}, longint'(cnt), m_cnt);
    cmp({tag, ".err_malformed"}, longint'(err_malformed), longint'(m_err));
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input bit m, input bit co,
                               input logic [DATA_W-1:0] s, input bit clr, input bit rdy,
                               input string tag);
    rst_n = rst; in_valid = v; in_m = m; in_co = co; in_s = s;
    acc_clr = clr; out_ready = rdy;
    #1;
    cmp({tag, ".in_ready"}, longint'(in_ready), longint'(!m_valid || rdy));
    model_edge();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  typedef struct {
    bit              m;
    bit              co;
    logic [DATA_W-1:0] s;
    longint          exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    longint cnt_before;

    vecs[0] = '{m: 1'b0, co: 1'b1, s: 16'hFFFF, exp: 131071};
    vecs[1] = '{m: 1'b0, co: 1'b0, s: 16'h0000, exp: 0};
    vecs[2] = '{m: 1'b0, co: 1'b0, s: 16'hFFFF, exp: 65535};
    vecs[3] = '{m: 1'b0, co: 1'b1, s: 16'h0000, exp: 65536};
    vecs[4] = '{m: 1'b1, co: 1'b1, s: 16'hFFFF, exp: 65535};
    vecs[5] = '{m: 1'b1, co: 1'b0, s: 16'hFFFF, exp: -65535};
    vecs[6] = '{m: 1'b1, co: 1'b0, s: 16'h0001, exp: -1};
    vecs[7] = '{m: 1'b1, co: 1'b0, s: 16'h0000, exp: 0};

    applyStimulus(0, 0, 0, 0, '0, 0, 1, "reset0");
    applyStimulus(0, 0, 0, 0, '0, 0, 1, "reset1");
    applyStimulus(1, 0, 0, 0, '0, 0, 1, "idle");
    cmp("idle.in_ready_const", longint'(in_ready), 1);

    applyStimulus(1, 1, 0, 1, 16'hFFFF, 0, 1, "t1");
    cmp("t1.value_const", sv_value(), 131071);
    cmp("t1.acc_const", sv_acc(), 131071);
    cmp("t1.cnt_const", longint'(cnt), 1);

    applyStimulus(1, 1, 1, 0, 16'h0005, 0, 1, "t2");
    cmp("t2.value_raw", longint'(out_value), longint'(18'h3FFFB));
    cmp("t2.acc_const", sv_acc(), 131066);
    cmp("t2.cnt_const", longint'(cnt), 2);

    applyStimulus(1, 0, 0, 0, '0, 0, 1, "bp_drain0");
    applyStimulus(1, 1, 0, 0, 16'h0011, 0, 0, "bp_a");
    cmp("bp_a.in_ready_low", longint'(in_ready), 0);
    cnt_before = longint'(cnt);
    applyStimulus(1, 1, 0, 0, 16'h0022, 0, 0, "bp_hold0");
    applyStimulus(1, 1, 0, 0, 16'h0022, 0, 0, "bp_hold1");
    cmp("bp_hold.value_frozen", sv_value(), 17);
    cmp("bp_hold.cnt_frozen", longint'(cnt), cnt_before);
    applyStimulus(1, 1, 0, 0, 16'h0022, 0, 1, "bp_release");
    cmp("bp_release.value", sv_value(), 34);
    cmp("bp_release.cnt", longint'(cnt), cnt_before + 1);
    applyStimulus(1, 0, 0, 0, '0, 0, 1, "bp_drain1");
    cmp("bp_drain1.no_dup", longint'(cnt), cnt_before + 1);

    applyStimulus(1, 0, 0, 0, '0, 1, 1, "clr_alone");
    for (int i = 0; i < 64; i++) applyStimulus(1, 1, 0, 1, 16'hFFFE, 0, 1, "sat_up");
    cmp("sat_up64.acc", sv_acc(), 8388480);
    cmp("sat_up64.sat", longint'(acc_sat), 0);
    applyStimulus(1, 1, 0, 1, 16'hFFFE, 0, 1, "sat_up65");
    cmp("sat_up65.acc", sv_acc(), 8388607);
    cmp("sat_up65.sat", longint'(acc_sat), 1);

    applyStimulus(1, 1, 1, 1, 16'h0007, 1, 1, "clr_xfer");
    cmp("clr_xfer.acc", sv_acc(), 7);
    cmp("clr_xfer.cnt", longint'(cnt), 1);
    cmp("clr_xfer.sat", longint'(acc_sat), 0);
    applyStimulus(1, 1, 1, 0, 16'h0000, 0, 1, "neg_zero");
    cmp("neg_zero.value", sv_value(), 0);
    cmp("neg_zero.err", longint'(err_malformed), 1);
    applyStimulus(1, 0, 0, 0, '0, 1, 1, "clr_keeps_err");
    cmp("clr_keeps_err.err", longint'(err_malformed), 1);

    for (int i = 0; i < 130; i++) applyStimulus(1, 1, 1, 0, 16'hFFFF, 0, 1, "sat_dn");
    cmp("sat_dn.acc", sv_acc(), ACC_MIN);
    cmp("sat_dn.sat", longint'(acc_sat), 1);

    applyStimulus(1, 0, 0, 0, '0, 1, 1, "tbl_clr");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, vecs[i].m, vecs[i].co, vecs[i].s, 0, 1, "tbl");
      cmp($sformatf("tbl[%0d].value", i), sv_value(), vecs[i].exp);
    end

    for (int i = 0; i < 600; i++) begin
      logic [DATA_W-1:0] rs;
      rs = ($urandom_range(0, 1) == 0) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
      applyStimulus(1, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), rs,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, "rand");
    end

    applyStimulus(1, 1, 0, 1, 16'h1234, 0, 0, "pre_rst");
    cmp("pre_rst.out_valid", longint'(out_valid), 1);
    applyStimulus(0, 1, 0, 1, 16'h4321, 0, 0, "mid_rst");
    cmp("mid_rst.out_valid", longint'(out_valid), 0);
    cmp("mid_rst.value", longint'(out_value), 0);
    cmp("mid_rst.acc", longint'(out_acc), 0);
    cmp("mid_rst.cnt", longint'(cnt), 0);
    cmp("mid_rst.sat", longint'(acc_sat), 0);
    cmp("mid_rst.err", longint'(err_malformed), 0);
    applyStimulus(1, 1, 1, 1, 16'h0003, 0, 1, "post_rst");
    cmp("post_rst.acc", sv_acc(), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
